// File: rtl/updown_counter_param_pkg.sv
// Shared constants and sizing helper for the parametrised up/down counter.
package counter_pkg;

  localparam logic DIR_UP    = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Bits needed to hold 0..val-1, never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned val);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < val) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/updown_counter_param_if.sv
// Control/data bundle between a counter user (master) and the counter (slave).
interface updown_counter_param_if #(
  parameter int unsigned WIDTH = 4
);

  logic             en;
  logic             sclr;
  logic             load;
  logic             dir;
  logic             sat;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] q;
  logic             tick;
  logic             tc;

  modport master (
    output en, sclr, load, dir, sat, din,
    input  q, tick, tc
  );

  modport slave (
    input  en, sclr, load, dir, sat, din,
    output q, tick, tc
  );

endinterface

// File: rtl/updown_counter_param_clk_en_div.sv
// Enable prescaler: strobes tick once every DIV enabled clocks; holds its phase while en is low.
module clk_en_div
  import counter_pkg::*;
#(
  parameter int unsigned DIV = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned   PW        = clog2_min1(DIV);
  localparam logic [PW-1:0] PCNT_LAST = PW'(DIV - 1);

  logic [PW-1:0] pcnt_q;
  logic [PW-1:0] pcnt_d;

  always_comb begin
    pcnt_d = pcnt_q;
    if (clr) begin
      pcnt_d = '0;
    end else if (en) begin
      if (pcnt_q == PCNT_LAST) begin
        pcnt_d = '0;
      end else begin
        pcnt_d = pcnt_q + PW'(1);
      end
    end else begin
      pcnt_d = pcnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

  assign tick = en && (pcnt_q == PCNT_LAST);

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with built-in prescaler, wrap/saturate mode and terminal-count pulse.
module updown_counter_param
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MAX     = (2 ** WIDTH) - 1,
  parameter int unsigned RST_VAL = 8,
  parameter int unsigned DIV     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  updown_counter_param_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             tick_s;
  logic             at_limit_s;

  clk_en_div #(
    .DIV (DIV)
  ) u_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (bus.sclr),
    .en   (bus.en),
    .tick (tick_s)
  );

  // >= / == guards keep any out-of-range value moving back into 0..MAX.
  always_comb begin
    q_d = q_q;
    if (bus.sclr) begin
      q_d = '0;
    end else if (tick_s) begin
      if (bus.load) begin
        q_d = (bus.din > MAX_V) ? MAX_V : bus.din;
      end else if (bus.dir == DIR_UP) begin
        if (q_q < MAX_V) begin
          q_d = q_q + WIDTH'(1);
        end else if (bus.sat == MODE_WRAP) begin
          q_d = '0;
        end else begin
          q_d = MAX_V;
        end
      end else begin
        if (q_q != '0) begin
          q_d = q_q - WIDTH'(1);
        end else if (bus.sat == MODE_WRAP) begin
          q_d = MAX_V;
        end else begin
          q_d = '0;
        end
      end
    end else begin
      q_d = q_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= RST_V;
    end else begin
      q_q <= q_d;
    end
  end

  assign at_limit_s = (bus.dir == DIR_UP) ? (q_q >= MAX_V) : (q_q == '0);

  assign bus.q    = q_q;
  assign bus.tick = tick_s;
  assign bus.tc   = tick_s && !bus.load && !bus.sclr && at_limit_s;

endmodule

// File: tb/tb_updown_counter_param.sv
// Scoreboard bench for updown_counter_param with WIDTH=4, MAX=9, RST_VAL=8, DIV=3.
module tb_updown_counter_param;

  logic clk;
  logic rst;

  updown_counter_param_if #(.WIDTH(4)) cif ();

  updown_counter_param #(
    .WIDTH   (4),
    .MAX     (9),
    .RST_VAL (8),
    .DIV     (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (cif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks;
  int   errors;
  int   m_q;
  int   m_pcnt;
  logic m_tick;
  logic m_tc;
  logic dut_tick;
  logic dut_tc;
  int   exp_q_queue[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive inputs, check combinational outputs, predict and later check q.
  task automatic run_cycle(input logic r, input logic e, input logic sc, input logic ld,
                           input logic dr, input logic st, input logic [3:0] d);
    int exp_q;
    @(negedge clk);
    rst      = r;
    cif.en   = e;
    cif.sclr = sc;
    cif.load = ld;
    cif.dir  = dr;
    cif.sat  = st;
    cif.din  = d;
    m_tick = e && (m_pcnt == 2);
    m_tc   = m_tick && !ld && !sc && ((!dr && m_q == 9) || (dr && m_q == 0));
    #1;
    dut_tick = cif.tick;
    dut_tc   = cif.tc;
    check_val("tick", {31'd0, dut_tick}, {31'd0, m_tick});
    check_val("tc", {31'd0, dut_tc}, {31'd0, m_tc});
    if (r) begin
      m_q = 8; m_pcnt = 0;
    end else if (sc) begin
      m_q = 0; m_pcnt = 0;
    end else begin
      if (e) m_pcnt = (m_pcnt == 2) ? 0 : m_pcnt + 1;
      if (m_tick) begin
        if (ld)                  m_q = (d > 4'd9) ? 9 : int'(d);
        else if (!dr && m_q < 9) m_q = m_q + 1;
        else if (!dr)            m_q = st ? 9 : 0;
        else if (m_q > 0)        m_q = m_q - 1;
        else                     m_q = st ? 0 : 9;
      end
    end
    exp_q_queue.push_back(m_q);
    @(posedge clk);
    #1;
    if (exp_q_queue.size() == 0) begin
      check_val("q_queue_empty", 32'd1, 32'd0);
    end else begin
      exp_q = exp_q_queue.pop_front();
      check_val("q", {28'd0, cif.q}, exp_q);
    end
  endtask

  initial begin
    int cnt;
    int first;
    checks   = 0;
    errors   = 0;
    m_q      = 8;
    m_pcnt   = 0;
    rst      = 1'b1;
    cif.en   = 1'b0;
    cif.sclr = 1'b0;
    cif.load = 1'b0;
    cif.dir  = 1'b0;
    cif.sat  = 1'b0;
    cif.din  = 4'd0;

    // 1: reset, then count up through 9 and wrap to 0.
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    check_val("rst_q", {28'd0, cif.q}, 32'd8);
    for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    check_val("up_to_9", {28'd0, cif.q}, 32'd9);
    for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    check_val("wrap_tc", {31'd0, dut_tc}, 32'd1);
    check_val("wrap_to_0", {28'd0, cif.q}, 32'd0);

    // 2: down-wrap from 0, then saturate at 0.
    for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    check_val("down_wrap_tc", {31'd0, dut_tc}, 32'd1);
    check_val("down_wrap_9", {28'd0, cif.q}, 32'd9);
    run_cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
    cnt = 0;
    for (int i = 0; i < 9; i++) begin
      run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
      if (dut_tc) cnt = cnt + 1;
    end
    check_val("sat_tc_count", cnt, 32'd3);
    check_val("sat_hold_0", {28'd0, cif.q}, 32'd0);

    // 3: clamped load lands only on the tick; load suppresses tc at MAX.
    run_cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd12);
    run_cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd12);
    check_val("load_not_before", {28'd0, cif.q}, 32'd0);
    run_cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd12);
    check_val("load_clamp", {28'd0, cif.q}, 32'd9);
    for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd5);
    check_val("load_tc_low", {31'd0, dut_tc}, 32'd0);
    check_val("load_5", {28'd0, cif.q}, 32'd5);

    // 4: clear mid-prescale restarts the phase.
    for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    check_val("down_to_4", {28'd0, cif.q}, 32'd4);
    run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    run_cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    check_val("sclr_q", {28'd0, cif.q}, 32'd0);
    first = 0;
    for (int i = 1; i <= 3; i++) begin
      run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      if (dut_tick && first == 0) first = i;
    end
    check_val("sclr_tick_phase", first, 32'd3);

    // 5: en low freezes the prescaler phase.
    run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 5; i++) run_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd7);
    check_val("en_hold_q", {28'd0, cif.q}, 32'd1);
    first = 0;
    for (int i = 1; i <= 3; i++) begin
      run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      if (dut_tick && first == 0) first = i;
    end
    check_val("en_resume_phase", first, 32'd2);

    // 6: rst beats sclr/load; sclr beats load on a tick.
    run_cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3);
    check_val("rst_prio", {28'd0, cif.q}, 32'd8);
    run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    run_cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3);
    check_val("sclr_on_tick", {31'd0, dut_tick}, 32'd1);
    check_val("sclr_beats_load", {28'd0, cif.q}, 32'd0);

    // Random mix against the model.
    for (int i = 0; i < 300; i++) begin
      run_cycle(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
                ($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0,
                ($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0,
                ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
                1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)),
                4'($urandom_range(0, 15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/updown_counter_param.md
Name: updown_counter_param

Overview:
- Parametrised successor to the lab 4-bit up/down counter.
- Configurable width, modulus, reset value and built-in enable prescaler, so the bench no longer generates the ena strobe externally.
- Adds wrap/saturate mode and a terminal-count pulse.
- Used as a timebase/event counter in the lab top levels.

Parameters:
- WIDTH, 4, counter width in bits.
- MAX, 2**WIDTH-1, highest count value; counter range is 0..MAX; MAX <= 2**WIDTH-1.
- RST_VAL, 8, value loaded by rst; must be <= MAX.
- DIV, 3, prescale ratio; one count tick every DIV enabled clocks; DIV=1 gives a tick every enabled clock.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  prescaler enable; when 0, prescaler and counter hold.
- sclr  input  1  synchronous clear, active-high, not gated by tick.
- load  input  1  load din on next tick.
- dir  input  1  0 = count up, 1 = count down.
- sat  input  1  0 = wrap at range limits, 1 = saturate.
- din  input  WIDTH  load data.
- q  output  WIDTH  counter value, registered.
- tick  output  1  prescaler strobe, combinational, high in the cycle the count updates.
- tc  output  1  terminal-count pulse, combinational.

Behaviour:
- Reset (rst=1 at rising edge): q <= RST_VAL, prescaler count pcnt <= 0. rst has priority over every other input.
- Prescaler:
  - pcnt is ceil(log2(DIV)) bits wide, minimum 1 bit.
  - When en=1, pcnt advances 0..DIV-1 and wraps to 0.
  - tick = en && (pcnt == DIV-1).
  - When en=0, pcnt holds and tick=0.
- Clear: sclr=1 and rst=0 gives q <= 0 and pcnt <= 0 on that edge, regardless of en or tick.
- Counter update happens only when tick=1, rst=0 and sclr=0. Priority order:
  - load=1: q <= din, clamped to MAX if din > MAX.
  - dir=0, q < MAX: q <= q+1.
  - dir=0, q == MAX: q <= 0 if sat=0; q holds MAX if sat=1.
  - dir=1, q > 0: q <= q-1.
  - dir=1, q == 0: q <= MAX if sat=0; q holds 0 if sat=1.
  - q values above MAX are unreachable.
- tc = tick && !load && !sclr && ((dir==0 && q==MAX) || (dir==1 && q==0)).
  - tc pulses for one cycle, coincident with the boundary edge.
  - tc pulses in both wrap and saturate modes.
- Latency: q changes on the edge that samples tick=1; load/dir/sat/din are sampled on that same edge only.
- Inputs between ticks have no effect, except sclr and rst.
- en dropped mid-prescale: pcnt frozen; the remaining cycles to the next tick are preserved when en returns.
- Simultaneous sclr and load: clear wins. rst with anything: RST_VAL wins.
- No undefined states; all registers are reset.

Decomposition:
- Shared package (counter_pkg) holds:
  - DIR_UP=1'b0, DIR_DOWN=1'b1;
  - MODE_WRAP=1'b0, MODE_SAT=1'b1;
  - a clog2-style width function for pcnt sizing.
- One sub-module, clk_en_div (parameter DIV; ports clk, rst, clr, en, tick), holds pcnt and the tick decode.
- The counter datapath and tc decode stay in updown_counter_param.

Test Plan:
All scenarios use WIDTH=4, MAX=9, RST_VAL=8, DIV=3.
1. rst=1 for 2 clocks, then rst=0, en=1, dir=0, sat=0 -> q=8 during reset; q=9 after 3rd edge; q=0 after 6th edge with tc=1 in the cycle before that edge; tick every 3rd clock.
2. q=0, dir=1, sat=0 -> next tick q=9 with tc=1. Repeat from 0 with sat=1 -> q stays 0 across 3 ticks, tc=1 on each.
3. load=1, din=12 -> q=9 at next tick, not before. Then din=5 -> q=5 at the following tick, tc=0 during load.
4. q=4, sclr=1 for one clock with pcnt=1 -> q=0 on that edge; next tick exactly 3 clocks after sclr deasserts.
5. en=0 for 5 clocks with pcnt=1 -> q and pcnt unchanged, tick=0; after en=1, tick after 2 clocks.
6. rst=1 together with sclr=1 and load=1, din=3 -> q=8, pcnt=0; a following sclr+load on a tick cycle -> q=0.
